// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART: register decode bits,
// STATUS bit positions and TX drain FSM encoding.
package uart_mmio_pkg;

    localparam int ADDR_TX_DATA = 1;
    localparam int ADDR_RX_DATA = 2;
    localparam int ADDR_STATUS  = 3;

    localparam int ST_TX_READY   = 0;
    localparam int ST_RX_AVAIL   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_TX_IDLE    = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACT,
        S_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; storage is not reset.
// Pop on empty is ignored; push on full only lands if a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: RX FIFO, TX buffer and serializer drain FSM.
// Define UART_TX_FIFO_EN for a TX_DEPTH FIFO instead of a one-byte holding register.
module uart_mmio #(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        io_sel,
    input  logic [29:0] word_addr,
    input  logic        rstrb,
    input  logic        wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte
);

    import uart_mmio_pkg::*;

    logic       rd_any;
    logic       rd_rx;
    logic       rd_st;
    logic       wr_tx;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;
    logic       rx_overrun;
    logic       tx_pending;
    logic       tx_ready;
    logic       tx_pop;
    logic       tx_idle;
    logic [7:0] tx_head;
    logic [31:0] status;
    tx_state_t  state;

    logic unused_bits;
    assign unused_bits = ^{word_addr[29:4], word_addr[0], wdata[31:8]};

    assign rd_any = io_sel & rstrb;
    assign rd_rx  = rd_any & word_addr[ADDR_RX_DATA];
    assign rd_st  = rd_any & word_addr[ADDR_STATUS];
    assign wr_tx  = io_sel & wstrb & word_addr[ADDR_TX_DATA];

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_valid),
        .pop    (rd_rx),
        .din    (rx_byte),
        .full   (rx_full),
        .empty  (rx_empty),
        .head   (rx_head)
    );

    // A pop frees the slot, so a coincident push into a full FIFO is not lost.
    always_ff @(posedge clk) begin
        if (!resetn)
            rx_overrun <= 1'b0;
        else if (rx_valid && rx_full && !rd_rx)
            rx_overrun <= 1'b1;
        else if (rd_st)
            rx_overrun <= 1'b0;
    end

`ifdef UART_TX_FIFO_EN
    logic tx_full;
    logic tx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (wr_tx & !tx_full),
        .pop    (tx_pop),
        .din    (wdata[7:0]),
        .full   (tx_full),
        .empty  (tx_empty),
        .head   (tx_head)
    );

    assign tx_pending = !tx_empty;
    assign tx_ready   = !tx_full;
`else
    logic [7:0] tx_hold;
    logic       tx_pend;

    always_ff @(posedge clk) begin
        if (!resetn)
            tx_pend <= 1'b0;
        else if (tx_pop)
            tx_pend <= 1'b0;
        else if (wr_tx)
            tx_pend <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_tx && !tx_pend) tx_hold <= wdata[7:0];
    end

    assign tx_head    = tx_hold;
    assign tx_pending = tx_pend;
    assign tx_ready   = !tx_pend;
`endif

    assign tx_pop  = (state == S_START);
    assign tx_idle = !tx_pending && (state == S_IDLE) && !tx_busy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (tx_pending && !tx_busy) begin
                        state    <= S_START;
                        tx_start <= 1'b1;
                        tx_byte  <= tx_head;
                    end
                end
                S_START: begin
                    state    <= S_WAIT_ACT;
                    tx_start <= 1'b0;
                end
                S_WAIT_ACT: begin
                    if (tx_busy) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        status                = '0;
        status[ST_TX_READY]   = tx_ready;
        status[ST_RX_AVAIL]   = !rx_empty;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_TX_IDLE]    = tx_idle;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (rd_any) begin
            unique case (1'b1)
                word_addr[ADDR_RX_DATA]:
                    rdata <= {24'b0, rx_empty ? 8'h00 : rx_head};
                word_addr[ADDR_STATUS]:
                    rdata <= status;
                default:
                    rdata <= '0;
            endcase
        end
    end

endmodule
